// File: rtl/seg_scan_display.sv
// Multiplexed 7-segment driver: valid/ready update path with hold-off, digit scan
// with inter-digit and leading-zero blanking. Define SEG_SCAN_DIMMING_EN for PWM brightness.
module seg_scan_display #(
  parameter int NUM_DIGITS   = 8,
  parameter int NUM_BANKS    = 2,
  parameter int REFRESH_DIV  = 65536,
  parameter int BLANK_CYCLES = 64,
  parameter int HOLD_CYCLES  = 50_000_000,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [4*NUM_DIGITS-1:0]   in_value,
  input  logic [NUM_DIGITS-1:0]     in_dp,
  input  logic                      lz_blank_en,
  input  logic                      freeze,
`ifdef SEG_SCAN_DIMMING_EN
  input  logic [3:0]                brightness,
`endif
  output logic [7*NUM_BANKS-1:0]    seg,
  output logic [NUM_BANKS-1:0]      dp,
  output logic [NUM_DIGITS-1:0]     anode,
  output logic [4*NUM_DIGITS-1:0]   shown_value,
  output logic                      update_pulse
);

  localparam int DPB       = NUM_DIGITS / NUM_BANKS;
  localparam int SLOT_W    = $clog2(REFRESH_DIV);
  localparam int DIG_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int HOLD_INIT = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;
  localparam int HOLD_W    = (HOLD_INIT > 0) ? $clog2(HOLD_INIT + 1) : 1;
  localparam logic INACT   = (ACTIVE_LOW != 0);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(REFRESH_DIV - 1);
  localparam logic [SLOT_W-1:0] BLANK_END = SLOT_W'(BLANK_CYCLES);
  localparam logic [DIG_W-1:0]  DIG_LAST  = DIG_W'(NUM_DIGITS - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_INIT);

  function automatic logic [6:0] decode7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
      4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
    endcase
    return s;
  endfunction

  function automatic logic [6:0] drive7(input logic [6:0] x);
    return (ACTIVE_LOW != 0) ? ~x : x;
  endfunction

  logic [4*NUM_DIGITS-1:0] shown_value_q, shown_value_d;
  logic [NUM_DIGITS-1:0]   dp_reg_q, dp_reg_d;
  logic [HOLD_W-1:0]       hold_cnt_q, hold_cnt_d;
  logic                    update_pulse_q, update_pulse_d;
  logic [SLOT_W-1:0]       slot_cnt_q, slot_cnt_d;
  logic [DIG_W-1:0]        digit_idx_q, digit_idx_d;
  logic [3:0]              snap_nib_q, snap_nib_d;
  logic                    snap_dp_q, snap_dp_d;
  logic                    snap_blank_q, snap_blank_d;
  logic [NUM_DIGITS-1:0]   anode_q, anode_d;
  logic [7*NUM_BANKS-1:0]  seg_q, seg_d;
  logic [NUM_BANKS-1:0]    dp_q, dp_d;
`ifdef SEG_SCAN_DIMMING_EN
  logic [3:0]              pwm_cnt_q, pwm_cnt_d;
`endif
  logic                    accept;
  logic [3:0]              live_nib;
  logic                    live_dp, live_blank;
  logic                    active_win, anode_on;

  assign in_ready = ~freeze & (hold_cnt_q == '0);
  assign accept   = in_valid & in_ready;

  // Update path: load on handshake, then hold off further updates
  always_comb begin
    shown_value_d  = shown_value_q;
    dp_reg_d       = dp_reg_q;
    hold_cnt_d     = hold_cnt_q;
    update_pulse_d = accept;
    if (accept) begin
      shown_value_d = in_value;
      dp_reg_d      = in_dp;
      if (HOLD_CYCLES > 0) hold_cnt_d = HOLD_LOAD;
    end else if (hold_cnt_q != '0) begin
      hold_cnt_d = hold_cnt_q - HOLD_W'(1);
    end
  end

  // Scan counters and per-slot snapshot of the selected digit
  always_comb begin
    logic zero_above;
    slot_cnt_d  = (slot_cnt_q == SLOT_LAST) ? '0 : slot_cnt_q + SLOT_W'(1);
    digit_idx_d = digit_idx_q;
    if (slot_cnt_q == SLOT_LAST)
      digit_idx_d = (digit_idx_q == DIG_LAST) ? '0 : digit_idx_q + DIG_W'(1);
    live_nib   = 4'h0;
    live_dp    = 1'b0;
    live_blank = 1'b0;
    zero_above = 1'b1;
    for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
      zero_above = zero_above & (shown_value_q[4*d +: 4] == 4'h0);
      if (digit_idx_q == DIG_W'(d)) begin
        live_nib   = shown_value_q[4*d +: 4];
        live_dp    = dp_reg_q[d];
        live_blank = lz_blank_en & zero_above & (d != 0);
      end
    end
    snap_nib_d   = snap_nib_q;
    snap_dp_d    = snap_dp_q;
    snap_blank_d = snap_blank_q;
    if (slot_cnt_q == '0) begin
      snap_nib_d   = live_nib;
      snap_dp_d    = live_dp;
      snap_blank_d = live_blank;
    end
  end

  // Output stage: uses the snapshot as it stands this cycle so slot 0 is consistent
  always_comb begin
    anode_d    = {NUM_DIGITS{INACT}};
    seg_d      = {7*NUM_BANKS{INACT}};
    dp_d       = {NUM_BANKS{INACT}};
    active_win = (slot_cnt_q >= BLANK_END);
    anode_on   = active_win;
`ifdef SEG_SCAN_DIMMING_EN
    pwm_cnt_d  = pwm_cnt_q + 4'd1;
    anode_on   = active_win & (pwm_cnt_q < brightness);
`endif
    if (active_win) begin
      for (int d = 0; d < NUM_DIGITS; d++) begin
        if (digit_idx_q == DIG_W'(d)) begin
          if (anode_on) anode_d[d] = ~INACT;
          seg_d[7*(d/DPB) +: 7] = drive7(snap_blank_d ? 7'h00 : decode7(snap_nib_d));
          dp_d[d/DPB]           = snap_dp_d ^ INACT;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shown_value_q  <= '0;
      dp_reg_q       <= '0;
      hold_cnt_q     <= '0;
      update_pulse_q <= 1'b0;
      slot_cnt_q     <= '0;
      digit_idx_q    <= '0;
      snap_nib_q     <= 4'h0;
      snap_dp_q      <= 1'b0;
      snap_blank_q   <= 1'b0;
      anode_q        <= {NUM_DIGITS{INACT}};
      seg_q          <= {7*NUM_BANKS{INACT}};
      dp_q           <= {NUM_BANKS{INACT}};
`ifdef SEG_SCAN_DIMMING_EN
      pwm_cnt_q      <= 4'd0;
`endif
    end else begin
      shown_value_q  <= shown_value_d;
      dp_reg_q       <= dp_reg_d;
      hold_cnt_q     <= hold_cnt_d;
      update_pulse_q <= update_pulse_d;
      slot_cnt_q     <= slot_cnt_d;
      digit_idx_q    <= digit_idx_d;
      snap_nib_q     <= snap_nib_d;
      snap_dp_q      <= snap_dp_d;
      snap_blank_q   <= snap_blank_d;
      anode_q        <= anode_d;
      seg_q          <= seg_d;
      dp_q           <= dp_d;
`ifdef SEG_SCAN_DIMMING_EN
      pwm_cnt_q      <= pwm_cnt_d;
`endif
    end
  end

  assign seg          = seg_q;
  assign dp           = dp_q;
  assign anode        = anode_q;
  assign shown_value  = shown_value_q;
  assign update_pulse = update_pulse_q;

endmodule
